// File: rtl/alarm_watcher_if.sv
// alarm_watcher_if: one-second time broadcast from the timekeeper (master) to its consumers (slave)
//   time_valid  one-cycle strobe per second; cur_* are valid in that cycle
//   cur_hour    binary 0-23
//   cur_min     binary 0-59
//   cur_sec     binary 0-59
interface alarm_watcher_if;
  logic       time_valid;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  modport master (output time_valid, cur_hour, cur_min, cur_sec);
  modport slave (input time_valid, cur_hour, cur_min, cur_sec);
endinterface

// File: rtl/alarm_watcher.sv
// alarm_watcher: alarm compare, ring/snooze/stop control, buzzer and status drive
//   clk, rst_n      clock, asynchronous active-low reset
//   tbus            time broadcast (alarm_watcher_if.slave)
//   alarm_enable    level; low forces IDLE and blocks ringing
//   set_hour/min    new alarm time, latched by alarm_load (rejected loads pulse load_err)
//   snooze_btn      one-cycle pulse, RINGING -> SNOOZE
//   stop_btn        one-cycle pulse, RINGING/SNOOZE -> IDLE
//   alarm_hour/min  registered alarm time
//   ringing         high in RINGING
//   snoozing        high in SNOOZE
//   buzzer          toggles on each strobe while ringing
// Optional: define SNOOZE_LIMIT_EN to cap snoozes per alarm event at MAX_SNOOZE.
module alarm_watcher #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alarm_watcher_if.slave        tbus,
  input  logic                  alarm_enable,
  input  logic [4:0]            set_hour,
  input  logic [5:0]            set_min,
  input  logic                  alarm_load,
  input  logic                  snooze_btn,
  input  logic                  stop_btn,
  output logic [4:0]            alarm_hour,
  output logic [5:0]            alarm_min,
  output logic                  load_err,
  output logic                  ringing,
  output logic                  snoozing,
  output logic                  buzzer
);
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;
  state_t     state;
  logic [7:0] ring_cnt;
  logic [4:0] last_hour, snz_hour, tgt_hour, nxt_hour;
  logic [5:0] last_min, snz_min, tgt_min, nxt_min;
  logic [6:0] min_sum;
  logic       carry, load_ok, hit, timeout, quit, take_snooze, snooze_ok;
  always_comb begin
    // snooze target = last sampled time + SNOOZE_MIN, wrapping 60 min / 24 h
    min_sum     = 7'(last_min) + 7'(SNOOZE_MIN);
    carry       = min_sum >= 7'd60;
    nxt_min     = carry ? 6'(min_sum - 7'd60) : min_sum[5:0];
    nxt_hour    = !carry ? last_hour : (last_hour == 5'd23 ? 5'd0 : last_hour + 5'd1);
    tgt_hour    = state == SNOOZE ? snz_hour : alarm_hour;
    tgt_min     = state == SNOOZE ? snz_min : alarm_min;
    hit         = tbus.time_valid & alarm_enable & tbus.cur_sec == 6'd0 &
                  tbus.cur_hour == tgt_hour & tbus.cur_min == tgt_min;
    timeout     = tbus.time_valid & ring_cnt == 8'(RING_TIMEOUT_S - 1);
    load_ok     = set_hour < 5'd24 & set_min < 6'd60;
    // priority: disable, then stop, then timeout all beat snooze
    quit        = !alarm_enable | (state != IDLE & stop_btn) | (state == RINGING & timeout);
    take_snooze = state == RINGING & snooze_btn & snooze_ok;
  end
`ifdef SNOOZE_LIMIT_EN
  localparam int SW = $clog2(MAX_SNOOZE + 1);
  logic [SW-1:0] snooze_cnt;
  assign snooze_ok = snooze_cnt != SW'(MAX_SNOOZE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) snooze_cnt <= '0;
    else if (quit) snooze_cnt <= '0;
    else if (take_snooze) snooze_cnt <= snooze_cnt + SW'(1);
`else
  localparam int max_snooze_unused = MAX_SNOOZE;
  assign snooze_ok = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      ring_cnt   <= '0;
      alarm_hour <= '0;
      alarm_min  <= '0;
      last_hour  <= '0;
      last_min   <= '0;
      snz_hour   <= '0;
      snz_min    <= '0;
      load_err   <= 1'b0;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
      buzzer     <= 1'b0;
    end else begin
      load_err <= alarm_load & !load_ok;
      if (alarm_load & load_ok) begin
        alarm_hour <= set_hour;
        alarm_min  <= set_min;
      end
      if (tbus.time_valid) begin
        last_hour <= tbus.cur_hour;
        last_min  <= tbus.cur_min;
      end
      if (quit) begin
        state    <= IDLE;
        ringing  <= 1'b0;
        snoozing <= 1'b0;
        buzzer   <= 1'b0;
      end else if (state != RINGING & hit) begin
        state    <= RINGING;
        ringing  <= 1'b1;
        snoozing <= 1'b0;
        buzzer   <= 1'b1;
        ring_cnt <= '0;
      end else if (take_snooze) begin
        state    <= SNOOZE;
        ringing  <= 1'b0;
        snoozing <= 1'b1;
        buzzer   <= 1'b0;
        snz_hour <= nxt_hour;
        snz_min  <= nxt_min;
      end else if (state == RINGING & tbus.time_valid) begin
        buzzer   <= ~buzzer;
        ring_cnt <= ring_cnt + 8'd1;
      end
    end
endmodule

// File: doc/alarm_watcher.md
Name: alarm_watcher

Overview:
- Consumer end of the timekeeper's time-broadcast interface: samples the current time on each one-second `time_valid` strobe.
- Holds the user-programmed alarm time and sounds the alarm when the time matches.
- Handles ringing, snooze and stop; drives the buzzer and status LEDs.
- Sits between the timekeeper, the debounced button block and the buzzer/LED outputs.

Parameters:
- SNOOZE_MIN, 5, minutes added to the current time on a snooze press (legal range 1-59).
- RING_TIMEOUT_S, 60, number of `time_valid` strobes spent in RINGING before an automatic return to IDLE (legal range 1-255).
- MAX_SNOOZE, 3, snooze presses allowed per alarm event; only used when SNOOZE_LIMIT_EN is defined.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- time_valid  in  1  one-cycle strobe, once per second; `cur_*` inputs are valid in that cycle.
- cur_hour  in  5  current hour, binary 0-23.
- cur_min  in  6  current minute, binary 0-59.
- cur_sec  in  6  current second, binary 0-59.
- alarm_enable  in  1  level; low forces IDLE and blocks ringing.
- set_hour  in  5  new alarm hour.
- set_min  in  6  new alarm minute.
- alarm_load  in  1  one-cycle pulse; latches `set_hour`/`set_min`.
- snooze_btn  in  1  one-cycle pulse (already debounced).
- stop_btn  in  1  one-cycle pulse (already debounced).
- alarm_hour  out  5  registered alarm hour.
- alarm_min  out  6  registered alarm minute.
- load_err  out  1  one-cycle pulse when a load is rejected.
- ringing  out  1  high in RINGING.
- snoozing  out  1  high in SNOOZE.
- buzzer  out  1  buzzer drive, 1 Hz on/off pattern.

Behaviour:
- Reset values:
  - Outputs: all 0; alarm time 00:00.
  - Internals: state IDLE; ring_cnt 0; snooze target 00:00; snooze_cnt 0.
  - Reset is asynchronous and may arrive mid-ring; everything returns to the above immediately.
- Load:
  - On `alarm_load` with `set_hour` < 24 and `set_min` < 60: alarm registers update the next cycle.
  - Otherwise registers are unchanged and `load_err`=1 for exactly one cycle.
  - A load is accepted in any state and does not change state.
- States: IDLE, RINGING, SNOOZE.
- Match condition: `time_valid` & `alarm_enable` & `cur_sec`==0 & (`cur_hour`,`cur_min`)==target.
  - target = alarm registers in IDLE; target = snooze target in SNOOZE.
  - Alarm registers are ignored while in SNOOZE.
- IDLE -> RINGING on match.
  - On entry: ring_cnt=0, `buzzer`=1.
  - `ringing` and `buzzer` go high the cycle after the matching strobe.
- RINGING:
  - Each `time_valid` toggles `buzzer` and increments ring_cnt.
  - When the strobe count reaches RING_TIMEOUT_S -> IDLE: `buzzer`=0, snooze_cnt=0.
- RINGING -> SNOOZE on `snooze_btn`:
  - snooze target = last sampled (`cur_hour`,`cur_min`) + SNOOZE_MIN.
  - Minutes wrap modulo 60 with a carry into hours; hours wrap modulo 24 (23:58 + 5 -> 00:03).
  - `buzzer`=0 next cycle.
  - "Last sampled" means registered on every `time_valid`, reset 00:00.
- SNOOZE -> RINGING on match; ring_cnt restarts at 0.
- `stop_btn` in RINGING or SNOOZE -> IDLE next cycle; `buzzer`=0, snooze_cnt=0.
- `alarm_enable` low in any state -> IDLE next cycle, same clearing as stop.
- Simultaneous events:
  - `stop_btn` and `snooze_btn` in the same cycle: stop wins.
  - `alarm_enable` low beats all other inputs.
  - `snooze_btn` arriving in the same cycle as the timeout strobe: timeout wins.
- `snooze_btn` and `stop_btn` in IDLE are ignored.
- A match in RINGING does not restart ring_cnt.

Optional Feature:
- Macro: SNOOZE_LIMIT_EN.
- Defined:
  - snooze_cnt (width fits MAX_SNOOZE) increments on each accepted snooze.
  - While snooze_cnt==MAX_SNOOZE, `snooze_btn` in RINGING is ignored; only stop, disable or timeout leave RINGING.
  - snooze_cnt clears on the return to IDLE.
- Undefined: no counter logic; snooze is always accepted.

Test Plan:
- Load 07:30 (set_hour=7, set_min=30), enable, drive strobes 07:29:59 then 07:30:00 -> `ringing`=1 and `buzzer`=1 the cycle after the 07:30:00 strobe; `buzzer` toggles on each following strobe.
- Load set_hour=24, set_min=10 -> `load_err` pulses for 1 cycle; `alarm_hour`/`alarm_min` keep 07:30.
- Ringing at 23:58:00, press snooze -> `snoozing`=1; strobe 00:03:00 -> `ringing`=1 (wrap check).
- Ringing, hold no buttons for RING_TIMEOUT_S=60 strobes -> IDLE after the 60th strobe, `buzzer`=0; `snooze_btn` and `stop_btn` pulsed in the same cycle while ringing -> IDLE, not SNOOZE.
- Deassert `alarm_enable` in SNOOZE -> IDLE next cycle; strobe at the snooze target -> no ring. Assert rst_n=0 mid-ring -> all outputs 0 immediately.
- With SNOOZE_LIMIT_EN and MAX_SNOOZE=3: 3 snoozes accepted; the 4th snooze press while ringing is ignored, `ringing` stays 1; `stop_btn` -> IDLE and the count clears, so the next alarm accepts 3 snoozes again.
